// File: rtl/multi_dataflow_engine_ctrl_pkg.sv
// Shared types and defaults for the engine-side controller responder.
package multi_dataflow_package;
  localparam int ENGINE_CNT_W       = 32;
  localparam int ENGINE_TIMEOUT_CYC = 1024;

  typedef enum logic [1:0] {
    E_IDLE  = 2'd0,
    E_RUN   = 2'd1,
    E_DRAIN = 2'd2,
    E_DONE  = 2'd3
  } engine_ctrl_state_t;
endpackage

// File: rtl/multi_dataflow_engine_ctrl_if.sv
// Controller / kernel / stream signals seen by the engine responder.
// slave = engine side, master = controller + kernel + sink side.
interface multi_dataflow_engine_ctrl_if
  import multi_dataflow_package::*;
#(
  parameter int CNT_W = ENGINE_CNT_W
) ();
  logic             ctrl_start_i;
  logic             ctrl_clear_i;
  logic             ctrl_enable_i;
  logic [CNT_W-1:0] ctrl_cnt_limit_i;
  logic             flags_ready_o;
  logic             flags_done_o;
  logic [CNT_W-1:0] flags_cnt_o;
  logic             kernel_ap_start_o;
  logic             kernel_ap_done_i;
  logic             kernel_ap_idle_i;
  logic             os_valid_i;
  logic             os_ready_i;
  logic             os_ready_o;
  logic             timeout_o;

  modport slave (
    input  ctrl_start_i, ctrl_clear_i, ctrl_enable_i, ctrl_cnt_limit_i,
    input  kernel_ap_done_i, kernel_ap_idle_i, os_valid_i, os_ready_i,
    output flags_ready_o, flags_done_o, flags_cnt_o,
    output kernel_ap_start_o, os_ready_o, timeout_o
  );

  modport master (
    output ctrl_start_i, ctrl_clear_i, ctrl_enable_i, ctrl_cnt_limit_i,
    output kernel_ap_done_i, kernel_ap_idle_i, os_valid_i, os_ready_i,
    input  flags_ready_o, flags_done_o, flags_cnt_o,
    input  kernel_ap_start_o, os_ready_o, timeout_o
  );
endinterface

// File: rtl/multi_dataflow_beat_counter.sv
// Accepted-beat counter with synchronous clear and a limit compare.
module multi_dataflow_beat_counter
  import multi_dataflow_package::*;
#(
  parameter int CNT_W = ENGINE_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic             i_beat,
  input  logic [CNT_W-1:0] i_limit,
  output logic [CNT_W-1:0] o_count,
  output logic             o_at_limit
);
  logic [CNT_W-1:0] r_count;

  // Count beats while enabled; clear wins over a same-cycle beat.
  always_ff @(posedge clk_i) begin
    if (rst_i || i_clear)        r_count <= '0;
    else if (i_enable && i_beat) r_count <= r_count + 1'b1;
  end

  assign o_count    = r_count;
  assign o_at_limit = (r_count == i_limit);
endmodule

// File: rtl/multi_dataflow_engine_ctrl.sv
// Engine-side responder between the HWPE controller FSM and the HLS kernel.
// Optional stall watchdog: define MULTI_DATAFLOW_ENGINE_CTRL_TIMEOUT_EN.
module multi_dataflow_engine_ctrl
  import multi_dataflow_package::*;
#(
  parameter int CNT_W       = ENGINE_CNT_W,
  parameter int TIMEOUT_CYC = ENGINE_TIMEOUT_CYC
) (
  input  logic clk_i,
  input  logic rst_i,
  multi_dataflow_engine_ctrl_if.slave eif
);
  engine_ctrl_state_t r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_limit;
  logic [CNT_W-1:0]   w_count;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_at_limit;
  logic               w_run;
  logic               w_start_acc;
  logic               w_beat;
  logic               w_os_ready;
  logic               w_timeout_hit;

  assign w_run       = (r_state == E_RUN);
  // A start is only honoured in idle, and a same-cycle clear cancels it.
  assign w_start_acc = (r_state == E_IDLE) & eif.ctrl_start_i & eif.ctrl_enable_i
                       & ~eif.ctrl_clear_i;
  // Counter never exceeds the limit in E_RUN, so !at_limit is counter<limit.
  assign w_os_ready  = eif.os_ready_i & eif.ctrl_enable_i & w_run & ~w_at_limit;
  assign w_beat      = eif.os_valid_i & w_os_ready;
  assign w_cnt_nxt   = w_count + CNT_W'(w_beat);

  multi_dataflow_beat_counter #(.CNT_W(CNT_W)) u_beat_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_clear    (eif.ctrl_clear_i | w_start_acc),
    .i_enable   (w_run & eif.ctrl_enable_i),
    .i_beat     (w_beat),
    .i_limit    (r_limit),
    .o_count    (w_count),
    .o_at_limit (w_at_limit)
  );

  // Latch the beat limit on an accepted start; held for the whole run.
  always_ff @(posedge clk_i) begin
    if (rst_i || eif.ctrl_clear_i) r_limit <= '0;
    else if (w_start_acc)          r_limit <= eif.ctrl_cnt_limit_i;
  end

`ifdef MULTI_DATAFLOW_ENGINE_CTRL_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);
  logic [STALL_W-1:0] r_stall;
  logic               r_timeout;

  assign w_timeout_hit = w_run & eif.ctrl_enable_i & ~w_beat
                         & (r_stall == STALL_W'(TIMEOUT_CYC - 1));

  // Stall watchdog: counts enabled E_RUN cycles without a beat.
  always_ff @(posedge clk_i) begin
    if (rst_i || eif.ctrl_clear_i || w_start_acc)  r_stall <= '0;
    else if (w_run && eif.ctrl_enable_i) begin
      if (w_beat || w_timeout_hit) r_stall <= '0;
      else                         r_stall <= r_stall + 1'b1;
    end
  end

  // Sticky timeout flag, dropped by reset, clear or the next accepted start.
  always_ff @(posedge clk_i) begin
    if (rst_i || eif.ctrl_clear_i || w_start_acc) r_timeout <= 1'b0;
    else if (w_timeout_hit)                       r_timeout <= 1'b1;
  end

  assign eif.timeout_o = r_timeout;
`else
  localparam int UNUSED_TIMEOUT_CYC = TIMEOUT_CYC;
  assign w_timeout_hit = 1'b0;
  assign eif.timeout_o = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= E_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; clear overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      E_IDLE:  if (w_start_acc)
                 w_state_nxt = (eif.ctrl_cnt_limit_i == '0) ? E_DONE : E_RUN;
      E_RUN:   if (w_beat && (w_cnt_nxt == r_limit)) w_state_nxt = E_DRAIN;
               else if (w_timeout_hit)               w_state_nxt = E_DONE;
      E_DRAIN: if (eif.kernel_ap_done_i || eif.kernel_ap_idle_i) w_state_nxt = E_DONE;
      E_DONE:  w_state_nxt = E_IDLE;
      default: w_state_nxt = E_IDLE;
    endcase
    if (eif.ctrl_clear_i) w_state_nxt = E_IDLE;
  end

  assign eif.flags_ready_o     = (r_state == E_IDLE);
  assign eif.flags_done_o      = (r_state == E_DONE);
  assign eif.flags_cnt_o       = w_count;
  assign eif.kernel_ap_start_o = w_run & eif.ctrl_enable_i;
  assign eif.os_ready_o        = w_os_ready;
endmodule

// File: tb/tb_multi_dataflow_engine_ctrl.sv
// Directed, table-driven bench for multi_dataflow_engine_ctrl.
module tb_multi_dataflow_engine_ctrl;
  import multi_dataflow_package::*;
  localparam int CNT_W = ENGINE_CNT_W;
  localparam int TO    = 10;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  multi_dataflow_engine_ctrl_if #(.CNT_W(CNT_W)) eif ();

  multi_dataflow_engine_ctrl #(.CNT_W(CNT_W), .TIMEOUT_CYC(TO)) u_dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .eif   (eif.slave)
  );

  typedef struct {
    string            tag;
    logic             st, cl, en;
    logic [CNT_W-1:0] lim;
    logic             val, rdy, apd, api;
    logic             e_ready, e_done;
    logic [CNT_W-1:0] e_cnt;
    logic             e_aps, e_osr;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t V(string tag, logic st, logic cl, logic en, logic [CNT_W-1:0] lim,
                             logic val, logic rdy, logic apd, logic api,
                             logic e_ready, logic e_done, logic [CNT_W-1:0] e_cnt,
                             logic e_aps, logic e_osr);
    vec_t v;
    v.tag = tag; v.st = st; v.cl = cl; v.en = en; v.lim = lim;
    v.val = val; v.rdy = rdy; v.apd = apd; v.api = api;
    v.e_ready = e_ready; v.e_done = e_done; v.e_cnt = e_cnt;
    v.e_aps = e_aps; v.e_osr = e_osr;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(logic st, logic cl, logic en, logic [CNT_W-1:0] lim,
                       logic val, logic rdy, logic apd, logic api);
    eif.ctrl_start_i     = st;
    eif.ctrl_clear_i     = cl;
    eif.ctrl_enable_i    = en;
    eif.ctrl_cnt_limit_i = lim;
    eif.os_valid_i       = val;
    eif.os_ready_i       = rdy;
    eif.kernel_ap_done_i = apd;
    eif.kernel_ap_idle_i = api;
  endtask

  task automatic chk_all(string tag, logic rdy, logic dn, logic [CNT_W-1:0] cnt,
                         logic aps, logic osr);
    chk({tag, ".ready"},    eif.flags_ready_o,     rdy);
    chk({tag, ".done"},     eif.flags_done_o,      dn);
    chk({tag, ".cnt"},      eif.flags_cnt_o,       cnt);
    chk({tag, ".ap_start"}, eif.kernel_ap_start_o, aps);
    chk({tag, ".os_ready"}, eif.os_ready_o,        osr);
  endtask

  initial begin
    // ---- Vector table: inputs for the cycle, outputs expected in that cycle
    // normal run, limit 8; start re-asserted with a different limit mid-run
    vq.push_back(V("norm", 1,0,1,8, 1,1,0,0, 1,0,0,0,0));
    for (int k = 0; k < 8; k++)
      vq.push_back(V("norm", (k == 2),0,1,3, 1,1,0,0, 0,0,k,1,1));
    vq.push_back(V("norm", 0,0,1,3, 1,1,0,0, 0,0,8,0,0));
    vq.push_back(V("norm", 0,0,1,3, 1,1,1,0, 0,0,8,0,0));
    vq.push_back(V("norm", 0,0,1,3, 1,1,0,0, 0,1,8,0,0));
    vq.push_back(V("norm", 0,0,1,3, 1,1,0,0, 1,0,8,0,0));
    // zero limit
    vq.push_back(V("zero", 1,0,1,0, 1,1,0,0, 1,0,8,0,0));
    vq.push_back(V("zero", 0,0,1,0, 1,1,0,0, 0,1,0,0,0));
    vq.push_back(V("zero", 0,0,1,0, 1,1,0,0, 1,0,0,0,0));
    // enable drop after beat 4; early ap_done in E_RUN ignored
    vq.push_back(V("endrop", 1,0,1,16, 1,1,0,0, 1,0,0,0,0));
    for (int k = 0; k < 4; k++)
      vq.push_back(V("endrop", 0,0,1,16, 1,1,0,0, 0,0,k,1,1));
    for (int k = 0; k < 5; k++)
      vq.push_back(V("endrop", 0,0,0,16, 1,1,0,0, 0,0,4,0,0));
    for (int k = 4; k < 16; k++)
      vq.push_back(V("endrop", 0,0,1,16, 1,1,(k == 9),0, 0,0,k,1,1));
    vq.push_back(V("endrop", 0,0,1,16, 1,1,0,1, 0,0,16,0,0));
    vq.push_back(V("endrop", 0,0,1,16, 1,1,0,0, 0,1,16,0,0));
    vq.push_back(V("endrop", 0,0,1,16, 1,1,0,0, 1,0,16,0,0));
    // clear together with start at beat 6; one sink back-pressure cycle
    vq.push_back(V("clr", 1,0,1,10, 1,1,0,0, 1,0,16,0,0));
    for (int k = 0; k < 3; k++)
      vq.push_back(V("clr", 0,0,1,10, 1,1,0,0, 0,0,k,1,1));
    vq.push_back(V("clr", 0,0,1,10, 1,0,0,0, 0,0,3,1,0));
    for (int k = 3; k < 6; k++)
      vq.push_back(V("clr", 0,0,1,10, 1,1,0,0, 0,0,k,1,1));
    vq.push_back(V("clr", 1,1,1,10, 1,1,0,0, 0,0,6,1,1));
    vq.push_back(V("clr", 0,0,1,10, 1,1,0,0, 1,0,0,0,0));
    vq.push_back(V("clr", 0,0,1,10, 1,1,0,0, 1,0,0,0,0));

    // ---- Reset: three cycles, then idle
    drive(0,0,0,'0, 0,0,0,0);
    rst_i = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    chk_all("rst", 1, 0, 0, 0, 0);
    chk("rst.timeout", eif.timeout_o, 0);
    rst_i = 1'b0;
    tick();
    chk_all("idle", 1, 0, 0, 0, 0);

    // ---- Table
    for (int i = 0; i < vq.size(); i++) begin
      vec_t v;
      string t;
      v = vq[i];
      drive(v.st, v.cl, v.en, v.lim, v.val, v.rdy, v.apd, v.api);
      #1;
      t = $sformatf("%s[%0d]", v.tag, i);
      chk_all(t, v.e_ready, v.e_done, v.e_cnt, v.e_aps, v.e_osr);
      chk({t, ".timeout"}, eif.timeout_o, 0);
      tick();
    end

    // ---- Maximum limit is accepted and does not gate early
    begin
      logic [CNT_W-1:0] lmax;
      lmax = '1;
      drive(1,0,1,lmax, 1,1,0,0);
      tick();
      drive(0,0,1,'0, 1,1,0,0);
      #1;
      chk_all("max.run0", 0, 0, 0, 1, 1);
      for (int k = 0; k < 3; k++) tick();
      chk_all("max.run3", 0, 0, 3, 1, 1);
      drive(0,1,1,'0, 1,1,0,0);
      tick();
      drive(0,0,1,'0, 0,0,0,0);
      #1;
      chk_all("max.clr", 1, 0, 0, 0, 0);
    end

    // ---- Stall watchdog
    drive(1,0,1,4, 0,1,0,0);
    tick();
    drive(0,0,1,4, 0,1,0,0);
`ifdef MULTI_DATAFLOW_ENGINE_CTRL_TIMEOUT_EN
    for (int k = 0; k < 9; k++) tick();
    chk("to.pre.timeout", eif.timeout_o, 0);
    chk("to.pre.done", eif.flags_done_o, 0);
    tick();
    chk("to.hit.timeout", eif.timeout_o, 1);
    chk("to.hit.done", eif.flags_done_o, 1);
    tick();
    chk("to.idle.timeout", eif.timeout_o, 1);
    chk("to.idle.ready", eif.flags_ready_o, 1);
    drive(1,0,1,0, 0,1,0,0);
    tick();
    drive(0,0,1,0, 0,1,0,0);
    #1;
    chk("to.restart.timeout", eif.timeout_o, 0);
    chk("to.restart.done", eif.flags_done_o, 1);
    tick();
`else
    for (int k = 0; k < 12; k++) tick();
    chk("to.off.timeout", eif.timeout_o, 0);
    chk("to.off.ap_start", eif.kernel_ap_start_o, 1);
    chk("to.off.done", eif.flags_done_o, 0);
    drive(0,1,1,0, 0,1,0,0);
    tick();
    drive(0,0,1,0, 0,1,0,0);
    #1;
    chk("to.off.clr", eif.flags_ready_o, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
